seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle iterative shift/rotate unit for the execute stage; the sequential counterpart to the single-cycle barrel shifter.
- Accepts one operation per start pulse and advances the operand one bit position per clock.
- Reports completion with a one-cycle done pulse.
- Serves long-latency shift paths and as a cross-check engine for the combinational ALU shifter.

Parameters:
- WIDTH, 16, data width in bits.
- CNT_W, 4, shift-count width; counts 0 to 2^CNT_W-1 are legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- flush  input  1  synchronous abort of the in-flight operation (pipeline squash).
- in  input  WIDTH  operand.
- cnt  input  CNT_W  shift/rotate amount.
- op  input  2  00=ROL, 01=SLL, 10=ROR, 11=SRL.
- busy  output  1  high while shifting; start is ignored while high.
- done  output  1  one-cycle pulse; out is valid in that cycle.
- out  output  WIDTH  result; holds until the next accepted start or reset.

Behaviour:
- Reset: async on rst high. state=IDLE, busy=0, done=0, out=0, internal data/count/op=0. Reset mid-operation discards all work; no done pulse.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
- Accept: start=1 at a rising edge while in IDLE or DONE (back-to-back allowed).
  - Latch in, op and remaining=cnt.
  - cnt==0: next state DONE, data=in.
  - Otherwise: next state SHIFT.
- SHIFT, each edge: data=step(data,op), remaining-=1. When remaining==1 at that edge, next state is DONE.
- Step rules:
  - ROL: {d[W-2:0],d[W-1]}.
  - SLL: {d[W-2:0],0}.
  - ROR: {d[0],d[W-1:1]}.
  - SRL: {0,d[W-1:1]}.
- DONE: out=data is registered on entry to DONE. Next edge goes to IDLE unless a new start is accepted.
- Latency: done asserts cnt+1 cycles after the accepting edge. cnt=0 gives 1 cycle; cnt=15 gives 16 cycles.
- start while busy: ignored. The request is not queued, and the in-flight operation is unaffected.
- flush (sync):
  - From any state, next state is IDLE and done=0.
  - out is not updated and keeps its previous value.
  - flush has priority over a simultaneous start.
- Illegal op values cannot occur (2-bit, fully decoded). The decode default is pass-through as a safety net.
- Inputs in, cnt and op are don't-care except on the accepting edge.

Decomposition:
- Shared package:
  - op localparams OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRL=2'b11, identical to the ALU shifter encoding.
  - State encoding ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: shift_step, a combinational one-bit step (data, op -> data'). It is instantiated once; the FSM, counter and output register remain in seq_shifter.

Test Plan:
- ROL, in=0x8001, cnt=1 -> busy for 1 cycle; done 2 cycles after start; out=0x0003.
- SRL, in=0x8000, cnt=15 -> done exactly 16 cycles after start; out=0x0001. Start pulses during busy are ignored, and out is unchanged until done.
- cnt=0, op=ROR, in=0xBEEF -> no busy cycle; done next cycle; out=0xBEEF. A back-to-back start in the DONE cycle (SLL, 0x0001, cnt=4) yields out=0x0010.
- ROR, in=0x0001, cnt=4 -> out=0x1000. SLL, in=0xFFFF, cnt=8 -> out=0xFF00.
- flush asserted on the 3rd SHIFT cycle of SRL 0xF000 cnt=10 -> IDLE next edge; no done; out keeps its prior value. flush and start in the same cycle -> start is dropped.
- rst pulsed asynchronously mid-SHIFT (between edges) -> busy, done and out go to 0 immediately. The first start after release behaves normally (ROL 0x1234 cnt=4 -> 0x2341).

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the iterative shifter: operation encoding (same as the
// ALU barrel shifter) and the controller state encoding.
package seq_shifter_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-position shift/rotate of a data word.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] q
);

  // one-bit step; the default passes data through unchanged
  always_comb begin
    q = d;
    case (op)
      OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
      OP_ROR:  q = {d[0], d[WIDTH-1:1]};
      OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock, one-cycle done
// pulse, result register that holds between operations.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] data_r, data_s, step_s, out_r;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic [1:0]       op_r, op_s;
  logic             busy_r, done_r;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d  (data_r),
    .op (op_r),
    .q  (step_s)
  );

  // next-state, operand and counter logic; flush overrides everything
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    rem_s   = rem_r;
    op_s    = op_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_s    = op;
            data_s  = in;
            rem_s   = cnt;
            state_s = (cnt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          data_s = step_s;
          rem_s  = rem_r - CNT_ONE;
          if (rem_r == CNT_ONE) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SHIFT;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // state, datapath and registered status/result; out loads only on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      data_r  <= {WIDTH{1'b0}};
      rem_r   <= CNT_ZERO;
      op_r    <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      out_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      rem_r   <= rem_s;
      op_r    <= op_s;
      busy_r  <= (state_s == ST_SHIFT);
      done_r  <= (state_s == ST_DONE);
      if (state_s == ST_DONE) begin
        out_r <= data_s;
      end else begin
        out_r <= out_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign out  = out_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter.
module tb_seq_shifter;

  logic        clk, rst, start, flush;
  logic [15:0] in;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic        busy, done;
  logic [15:0] out;

  int errors = 0;
  int checks = 0;

  seq_shifter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in(in), .cnt(cnt), .op(op),
    .busy(busy), .done(done), .out(out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Start an op (caller is #1 after an edge, block idle or in DONE), wait for done,
  // check latency (edges incl. the accepting one), busy cycles and result.
  task automatic run_op(input logic [1:0] o, input logic [15:0] d, input logic [3:0] c,
                        input logic [15:0] exp, input string name);
    int lat, bcnt;
    bit seen;
    start = 1'b1; op = o; in = d; cnt = c;
    @(posedge clk); #1;
    start = 1'b0; in = 16'h5A5A; cnt = 4'hF; op = 2'b11;
    lat = 1; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        lat++;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: done=%b expected 1", name, done);
    end
    checks++;
    if (lat !== c + 1) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, c + 1);
    end
    checks++;
    if (bcnt !== int'(c)) begin
      errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, bcnt, c);
    end
    checks++;
    if (out !== exp) begin
      errors++; $display("FAIL %s out: got %h expected %h", name, out, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; in = 16'h0; cnt = 4'h0; op = 2'b00;
    #12;
    checks++;
    if ({busy, done, out} !== 18'h0) begin
      errors++; $display("FAIL reset: got busy=%b done=%b out=%h expected 0/0/0000", busy, done, out);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, out} !== 18'h0) begin
      errors++; $display("FAIL post_reset: got busy=%b done=%b out=%h expected 0/0/0000", busy, done, out);
    end
  endtask

  task automatic test_rol_basic();
    run_op(2'b00, 16'h8001, 4'd1, 16'h0003, "rol_8001_1");
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=%b expected 0", done);
    end
  endtask

  task automatic test_srl_ignore_start();
    int lat;
    bit seen, out_ok;
    start = 1'b1; op = 2'b11; in = 16'h8000; cnt = 4'd15;
    @(posedge clk); #1;
    lat = 1; seen = 1'b0; out_ok = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) begin
        seen = 1'b1; start = 1'b0;
      end else begin
        start = 1'b1; op = 2'b00; in = 16'hFFFF; cnt = 4'd1;
        if (out !== 16'h0003) out_ok = 1'b0;
        lat++;
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen || lat !== 16) begin
      errors++; $display("FAIL srl_latency: got %0d (seen=%b) expected 16", lat, seen);
    end
    checks++;
    if (!out_ok) begin
      errors++; $display("FAIL out_hold_while_busy: got changed expected 0003");
    end
    checks++;
    if (out !== 16'h0001) begin
      errors++; $display("FAIL srl_8000_15 out: got %h expected 0001", out);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL stray_start_queued: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_zero_back_to_back();
    run_op(2'b10, 16'hBEEF, 4'd0, 16'hBEEF, "ror_beef_0");
    run_op(2'b01, 16'h0001, 4'd4, 16'h0010, "b2b_sll_0001_4");
  endtask

  task automatic test_ror_sll();
    run_op(2'b10, 16'h0001, 4'd4, 16'h1000, "ror_0001_4");
    run_op(2'b01, 16'hFFFF, 4'd8, 16'hFF00, "sll_ffff_8");
  endtask

  task automatic test_flush();
    bit any_done;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; in = 16'hF000; cnt = 4'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 16'hFF00) begin
      errors++; $display("FAIL flush_shift: got busy=%b done=%b out=%h expected 0/0/ff00", busy, done, out);
    end
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) any_done = 1'b1;
    end
    checks++;
    if (any_done) begin
      errors++; $display("FAIL flush_no_done: got done pulse expected none");
    end
    flush = 1'b1; start = 1'b1; op = 2'b00; in = 16'h0001; cnt = 4'd0;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 16'hFF00) begin
      errors++; $display("FAIL flush_vs_start: got busy=%b done=%b out=%h expected 0/0/ff00", busy, done, out);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = 2'b00; in = 16'hFFFF; cnt = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_busy: got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, out} !== 18'h0) begin
      errors++; $display("FAIL async_reset: got busy=%b done=%b out=%h expected 0/0/0000", busy, done, out);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, out} !== 18'h0) begin
      errors++; $display("FAIL after_async_reset: got busy=%b done=%b out=%h expected 0/0/0000", busy, done, out);
    end
    run_op(2'b00, 16'h1234, 4'd4, 16'h2341, "rol_1234_4");
  endtask

  initial begin
    test_reset();
    test_rol_basic();
    test_srl_ignore_start();
    test_zero_back_to_back();
    test_ror_sll();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
